// File: rtl/router_fsm_np.sv
// Packet-routing control FSM for a 1xN router: address decode, payload/parity write sequencing,
// full/busy stalls, drop of unroutable packets. Define ROUTER_FSM_TIMEOUT_EN for per-port read-timeout soft resets.
module router_fsm_np #(
  parameter int NUM_PORTS   = 3,
  parameter int ADDR_W      = 2,
  parameter int TIMEOUT_CYC = 30
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [ADDR_W-1:0]    data_in,
  input  logic                 pkt_valid,
  input  logic [NUM_PORTS-1:0] fifo_full,
  input  logic [NUM_PORTS-1:0] fifo_empty,
  input  logic [NUM_PORTS-1:0] read_enb,
  input  logic                 parity_done,
  input  logic                 low_pkt_valid,
  output logic                 detect_add,
  output logic                 lfd_state,
  output logic                 ld_state,
  output logic                 laf_state,
  output logic                 full_state,
  output logic                 write_enb_reg,
  output logic                 busy,
  output logic                 rst_int_reg,
  output logic [NUM_PORTS-1:0] dest_sel,
  output logic                 addr_err,
  output logic [NUM_PORTS-1:0] soft_reset
);

  typedef enum logic [3:0] {
    DECODE_ADDRESS     = 4'd0,
    LOAD_FIRST_DATA    = 4'd1,
    LOAD_DATA          = 4'd2,
    LOAD_PARITY        = 4'd3,
    FIFO_FULL_STATE    = 4'd4,
    LOAD_AFTER_FULL    = 4'd5,
    WAIT_TILL_EMPTY    = 4'd6,
    CHECK_PARITY_ERROR = 4'd7,
    DROP_PACKET        = 4'd8
  } state_t;

  // Output vector order: detect_add, lfd, ld, laf, full, write_enb, busy, rst_int, addr_err
  localparam logic [8:0] OUT_RESET = 9'b1_0000_0000;

  state_t               state_r;
  state_t               state_nxt_s;
  logic [8:0]           outs_r;
  logic [NUM_PORTS-1:0] dest_sel_r;
  logic [NUM_PORTS-1:0] addr_oh_s;
  logic [NUM_PORTS-1:0] sel_oh_s;
  logic                 valid_s;
  logic                 sel_full_s;
  logic                 sel_empty_s;
  logic                 abort_s;

  // An address outside the port range decodes to all-zero, which doubles as the invalid flag.
  function automatic logic [NUM_PORTS-1:0] onehot_addr(input logic [ADDR_W-1:0] addr);
    logic [NUM_PORTS-1:0] oh;
    oh = {NUM_PORTS{1'b0}};
    for (int i = 0; i < NUM_PORTS; i++) begin
      oh[i] = (addr == ADDR_W'(i));
    end
    return oh;
  endfunction

  function automatic logic [8:0] decode_outs(input state_t st);
    logic [8:0] o;
    o = 9'b0_0000_0000;
    case (st)
      DECODE_ADDRESS:     o = 9'b1_0000_0000;
      LOAD_FIRST_DATA:    o = 9'b0_1000_0100;
      LOAD_DATA:          o = 9'b0_0100_1000;
      LOAD_AFTER_FULL:    o = 9'b0_0010_1100;
      FIFO_FULL_STATE:    o = 9'b0_0001_0100;
      LOAD_PARITY:        o = 9'b0_0000_1100;
      CHECK_PARITY_ERROR: o = 9'b0_0000_0110;
      WAIT_TILL_EMPTY:    o = 9'b0_0000_0100;
      DROP_PACKET:        o = 9'b0_0000_0001;
      default:            o = 9'b1_0000_0000;
    endcase
    return o;
  endfunction

  assign addr_oh_s   = onehot_addr(data_in);
  assign valid_s     = |addr_oh_s;
  assign sel_oh_s    = (state_r == DECODE_ADDRESS) ? addr_oh_s : dest_sel_r;
  assign sel_full_s  = |(fifo_full & sel_oh_s);
  assign sel_empty_s = |(fifo_empty & sel_oh_s);

`ifdef ROUTER_FSM_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  logic [CNT_W-1:0]     tmo_cnt_r [NUM_PORTS];
  logic [NUM_PORTS-1:0] soft_reset_r;

  // Per-port unread-timeout counters; terminal count emits a one-cycle soft reset and restarts.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        tmo_cnt_r[i] <= {CNT_W{1'b0}};
      end
      soft_reset_r <= {NUM_PORTS{1'b0}};
    end else begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (fifo_empty[i] || read_enb[i]) begin
          tmo_cnt_r[i]    <= {CNT_W{1'b0}};
          soft_reset_r[i] <= 1'b0;
        end else if (tmo_cnt_r[i] == CNT_W'(TIMEOUT_CYC - 1)) begin
          tmo_cnt_r[i]    <= {CNT_W{1'b0}};
          soft_reset_r[i] <= 1'b1;
        end else begin
          tmo_cnt_r[i]    <= tmo_cnt_r[i] + CNT_W'(1);
          soft_reset_r[i] <= 1'b0;
        end
      end
    end
  end

  assign abort_s = (|(soft_reset_r & sel_oh_s)) &&
                   (state_r != DECODE_ADDRESS) && (state_r != DROP_PACKET);
  assign soft_reset = soft_reset_r;
`else
  logic unused_read_enb_s;
  assign unused_read_enb_s = ^read_enb;
  assign abort_s    = 1'b0;
  assign soft_reset = {NUM_PORTS{1'b0}};
`endif

  // Next-state logic; a soft reset on the selected port aborts the packet ahead of normal flow.
  always_comb begin
    state_nxt_s = state_r;
    if (abort_s) begin
      state_nxt_s = DECODE_ADDRESS;
    end else begin
      case (state_r)
        DECODE_ADDRESS: begin
          if (pkt_valid && valid_s && sel_empty_s) state_nxt_s = LOAD_FIRST_DATA;
          else if (pkt_valid && valid_s)           state_nxt_s = WAIT_TILL_EMPTY;
          else if (pkt_valid)                      state_nxt_s = DROP_PACKET;
          else                                     state_nxt_s = DECODE_ADDRESS;
        end
        LOAD_FIRST_DATA: state_nxt_s = LOAD_DATA;
        LOAD_DATA: begin
          if (sel_full_s)      state_nxt_s = FIFO_FULL_STATE;
          else if (!pkt_valid) state_nxt_s = LOAD_PARITY;
          else                 state_nxt_s = LOAD_DATA;
        end
        FIFO_FULL_STATE: begin
          if (!sel_full_s) state_nxt_s = LOAD_AFTER_FULL;
          else             state_nxt_s = FIFO_FULL_STATE;
        end
        LOAD_AFTER_FULL: begin
          if (parity_done)        state_nxt_s = DECODE_ADDRESS;
          else if (low_pkt_valid) state_nxt_s = LOAD_PARITY;
          else                    state_nxt_s = LOAD_DATA;
        end
        LOAD_PARITY: state_nxt_s = CHECK_PARITY_ERROR;
        CHECK_PARITY_ERROR: begin
          if (sel_full_s) state_nxt_s = FIFO_FULL_STATE;
          else            state_nxt_s = DECODE_ADDRESS;
        end
        WAIT_TILL_EMPTY: begin
          if (sel_empty_s) state_nxt_s = LOAD_FIRST_DATA;
          else             state_nxt_s = WAIT_TILL_EMPTY;
        end
        DROP_PACKET: begin
          if (pkt_valid) state_nxt_s = DROP_PACKET;
          else           state_nxt_s = DECODE_ADDRESS;
        end
        default: state_nxt_s = DECODE_ADDRESS;
      endcase
    end
  end

  // State register; outputs are registered from the next state so they always match state_r.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= DECODE_ADDRESS;
      outs_r  <= OUT_RESET;
    end else begin
      state_r <= state_nxt_s;
      outs_r  <= decode_outs(state_nxt_s);
    end
  end

  // Destination latch, captured only when a routable header is accepted.
  always_ff @(posedge clk) begin
    if (reset) begin
      dest_sel_r <= {NUM_PORTS{1'b0}};
    end else if ((state_r == DECODE_ADDRESS) && pkt_valid && valid_s) begin
      dest_sel_r <= addr_oh_s;
    end else begin
      dest_sel_r <= dest_sel_r;
    end
  end

  assign detect_add    = outs_r[8];
  assign lfd_state     = outs_r[7];
  assign ld_state      = outs_r[6];
  assign laf_state     = outs_r[5];
  assign full_state    = outs_r[4];
  assign write_enb_reg = outs_r[3];
  assign busy          = outs_r[2];
  assign rst_int_reg   = outs_r[1];
  assign addr_err      = outs_r[0];
  assign dest_sel      = dest_sel_r;

endmodule

// File: tb/tb_router_fsm_np.sv
// Directed bench for router_fsm_np (NUM_PORTS=3, TIMEOUT_CYC=30); expectations follow ROUTER_FSM_TIMEOUT_EN.
module tb_router_fsm_np;

  // Expected output vectors: detect_add, lfd, ld, laf, full, write_enb, busy, rst_int, addr_err
  localparam logic [8:0] S_DEC  = 9'b1_0000_0000;
  localparam logic [8:0] S_LFD  = 9'b0_1000_0100;
  localparam logic [8:0] S_LD   = 9'b0_0100_1000;
  localparam logic [8:0] S_LAF  = 9'b0_0010_1100;
  localparam logic [8:0] S_FFS  = 9'b0_0001_0100;
  localparam logic [8:0] S_LP   = 9'b0_0000_1100;
  localparam logic [8:0] S_CPE  = 9'b0_0000_0110;
  localparam logic [8:0] S_WAIT = 9'b0_0000_0100;
  localparam logic [8:0] S_DROP = 9'b0_0000_0001;

`ifdef ROUTER_FSM_TIMEOUT_EN
  localparam bit TMO = 1'b1;
`else
  localparam bit TMO = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] data_in;
  logic       pkt_valid;
  logic [2:0] fifo_full;
  logic [2:0] fifo_empty;
  logic [2:0] read_enb;
  logic       parity_done;
  logic       low_pkt_valid;
  logic       detect_add, lfd_state, ld_state, laf_state, full_state;
  logic       write_enb_reg, busy, rst_int_reg, addr_err;
  logic [2:0] dest_sel;
  logic [2:0] soft_reset;
  logic [8:0] obs_o;

  int n_pass = 0;
  int n_total = 0;

  router_fsm_np #(.NUM_PORTS(3), .ADDR_W(2), .TIMEOUT_CYC(30)) dut (
    .clk(clk), .reset(reset), .data_in(data_in), .pkt_valid(pkt_valid),
    .fifo_full(fifo_full), .fifo_empty(fifo_empty), .read_enb(read_enb),
    .parity_done(parity_done), .low_pkt_valid(low_pkt_valid),
    .detect_add(detect_add), .lfd_state(lfd_state), .ld_state(ld_state),
    .laf_state(laf_state), .full_state(full_state), .write_enb_reg(write_enb_reg),
    .busy(busy), .rst_int_reg(rst_int_reg), .dest_sel(dest_sel),
    .addr_err(addr_err), .soft_reset(soft_reset)
  );

  always #5 clk = ~clk;

  assign obs_o = {detect_add, lfd_state, ld_state, laf_state, full_state,
                  write_enb_reg, busy, rst_int_reg, addr_err};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [8:0] exp_o,
                     input logic [2:0] exp_dest, input logic [2:0] exp_sr);
    n_total++;
    assert (obs_o === exp_o) n_pass++;
    else $error("FAIL %s outs: got %b want %b", tag, obs_o, exp_o);
    n_total++;
    assert (dest_sel === exp_dest) n_pass++;
    else $error("FAIL %s dest_sel: got %b want %b", tag, dest_sel, exp_dest);
    n_total++;
    assert (soft_reset === exp_sr) n_pass++;
    else $error("FAIL %s soft_reset: got %b want %b", tag, soft_reset, exp_sr);
  endtask

  initial begin
    reset = 1'b1; data_in = 2'd0; pkt_valid = 1'b0; fifo_full = 3'b000;
    fifo_empty = 3'b111; read_enb = 3'b000; parity_done = 1'b0; low_pkt_valid = 1'b0;
    step(); step();
    chk("reset", S_DEC, 3'b000, 3'b000);
    reset = 1'b0;

    // 1: normal packet to port 0, pkt_valid sampled high on four edges
    data_in = 2'd0; pkt_valid = 1'b1;
    step(); chk("t1_lfd", S_LFD, 3'b001, 3'b000);
    step(); chk("t1_ld1", S_LD, 3'b001, 3'b000);
    step(); chk("t1_ld2", S_LD, 3'b001, 3'b000);
    step(); chk("t1_ld3", S_LD, 3'b001, 3'b000);
    pkt_valid = 1'b0;
    step(); chk("t1_lp", S_LP, 3'b001, 3'b000);
    step(); chk("t1_cpe", S_CPE, 3'b001, 3'b000);
    step(); chk("t1_dec", S_DEC, 3'b001, 3'b000);

    // 2: full stall, then low_pkt_valid exit, then CPE full and parity_done exit
    pkt_valid = 1'b1;
    step(); chk("t2_lfd", S_LFD, 3'b001, 3'b000);
    step(); chk("t2_ld", S_LD, 3'b001, 3'b000);
    fifo_full = 3'b001;
    step(); chk("t2_ffs1", S_FFS, 3'b001, 3'b000);
    step(); chk("t2_ffs2", S_FFS, 3'b001, 3'b000);
    step(); chk("t2_ffs3", S_FFS, 3'b001, 3'b000);
    fifo_full = 3'b000;
    step(); chk("t2_laf", S_LAF, 3'b001, 3'b000);
    step(); chk("t2_ld_again", S_LD, 3'b001, 3'b000);
    fifo_full = 3'b001;
    step(); step(); step(); chk("t2b_ffs", S_FFS, 3'b001, 3'b000);
    fifo_full = 3'b000; low_pkt_valid = 1'b1;
    step(); chk("t2b_laf", S_LAF, 3'b001, 3'b000);
    step(); chk("t2b_lp", S_LP, 3'b001, 3'b000);
    low_pkt_valid = 1'b0; pkt_valid = 1'b0;
    step(); chk("t2b_cpe", S_CPE, 3'b001, 3'b000);
    fifo_full = 3'b001;
    step(); chk("t2c_cpe_full", S_FFS, 3'b001, 3'b000);
    fifo_full = 3'b000; parity_done = 1'b1;
    step(); chk("t2c_laf", S_LAF, 3'b001, 3'b000);
    step(); chk("t2c_pd_dec", S_DEC, 3'b001, 3'b000);
    parity_done = 1'b0;

    // 3: busy destination port 2; data_in changes in WAIT must be ignored
    fifo_empty = 3'b011; data_in = 2'd2; pkt_valid = 1'b1;
    step(); chk("t3_wait1", S_WAIT, 3'b100, 3'b000);
    data_in = 2'd0;
    step(); chk("t3_wait2", S_WAIT, 3'b100, 3'b000);
    step(); chk("t3_wait3", S_WAIT, 3'b100, 3'b000);
    fifo_empty = 3'b111;
    step(); chk("t3_lfd", S_LFD, 3'b100, 3'b000);
    pkt_valid = 1'b0;
    step(); chk("t3_ld", S_LD, 3'b100, 3'b000);
    step(); chk("t3_lp", S_LP, 3'b100, 3'b000);
    step(); chk("t3_cpe", S_CPE, 3'b100, 3'b000);
    step(); chk("t3_dec", S_DEC, 3'b100, 3'b000);

    // 4: invalid address 3 streamed for five cycles
    data_in = 2'd3; pkt_valid = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      step(); chk($sformatf("t4_drop%0d", k), S_DROP, 3'b100, 3'b000);
    end
    pkt_valid = 1'b0;
    step(); chk("t4_dec", S_DEC, 3'b100, 3'b000);

    // 5a: port 0 unread from the header cycle on; pulse expected 30 cycles later
    data_in = 2'd0; fifo_empty = 3'b110; pkt_valid = 1'b1;
    for (int k = 1; k <= 31; k++) begin
      step();
      if (k == 1) pkt_valid = 1'b0;
      chk($sformatf("t5a_c%0d", k), (TMO && k == 31) ? S_DEC : S_WAIT, 3'b001,
          (TMO && k == 30) ? 3'b001 : 3'b000);
    end
    fifo_empty = 3'b111;
    for (int k = 0; k < 6; k++) step();
    chk("t5a_recover", S_DEC, 3'b001, 3'b000);

    // 5b: a read at cycle 20 restarts the count, moving the pulse to cycle 50
    fifo_empty = 3'b110; pkt_valid = 1'b1;
    for (int k = 1; k <= 51; k++) begin
      step();
      if (k == 1) pkt_valid = 1'b0;
      if (k == 19) read_enb = 3'b001;
      if (k == 20) read_enb = 3'b000;
      chk($sformatf("t5b_c%0d", k), (TMO && k == 51) ? S_DEC : S_WAIT, 3'b001,
          (TMO && k == 50) ? 3'b001 : 3'b000);
    end
    fifo_empty = 3'b111;
    for (int k = 0; k < 6; k++) step();
    chk("t5b_recover", S_DEC, 3'b001, 3'b000);

    // 6: packet to port 1; fullness of another port is ignored; reset in FIFO_FULL_STATE
    data_in = 2'd1; pkt_valid = 1'b1;
    step(); chk("t6_lfd", S_LFD, 3'b010, 3'b000);
    step(); chk("t6_ld", S_LD, 3'b010, 3'b000);
    data_in = 2'd0; fifo_full = 3'b001;
    step(); chk("t6_other_full", S_LD, 3'b010, 3'b000);
    fifo_full = 3'b010;
    step(); chk("t6_ffs", S_FFS, 3'b010, 3'b000);
    reset = 1'b1;
    step(); chk("t6_reset", S_DEC, 3'b000, 3'b000);
    reset = 1'b0; fifo_full = 3'b000; pkt_valid = 1'b0;
    step(); chk("t6_idle", S_DEC, 3'b000, 3'b000);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
